sq_commit_scheduler: RTL and testbench

- Pointer and drain controller for the circular store queue (SQ).
- Tracks allocation (tail), ROB commit (commit pointer) and drain (head).
- Sequences committed stores into the D-cache store port one at a time, oldest first, using a valid/ready handshake with miss-retry.
- Exports head/tail pointers so the store-forwarding priority selector can use head_idx as its circular start position.

---
 rtl/sq_commit_scheduler.sv | 146 ++++++++++++++
 tb/tb_sq_commit_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_commit_scheduler.sv
// Store-queue pointer/drain controller: tracks alloc (tail), ROB commit (cptr) and drain (head).
// Latency: one store presented per cycle from head; free pulse appears the cycle after the D-cache accepts.
// Backpressure: request held stable until st_req_ready; a miss parks in MISS_WAIT until refill_done.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   alloc_en/alloc_idx    dispatch allocation at tail; alloc_idx is the slot granted
//   retire_en             ROB commits the oldest uncommitted store
//   squash                drop all uncommitted entries (committed ones survive)
//   drain_hold            blocks new drain requests, not an outstanding one
//   st_req_*              D-cache store port (valid/ready, st_hit qualifies ready)
//   refill_done           miss for the pending store resolved
//   head_idx/tail_idx     circular pointers for the forwarding selector
//   sq_full/sq_empty      occupancy flags from the entry count
//   free_valid/free_idx   registered one-cycle release of a drained entry

`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

module sq_commit_scheduler #(
   parameter int N  = `SQ_SIZE,
   parameter int IW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          alloc_en,
   input  logic          retire_en,
   input  logic          squash,
   input  logic          drain_hold,
   input  logic          st_req_ready,
   input  logic          st_hit,
   input  logic          refill_done,
   output logic [IW-1:0] alloc_idx,
   output logic          sq_full,
   output logic          sq_empty,
   output logic [IW-1:0] head_idx,
   output logic [IW-1:0] tail_idx,
   output logic          st_req_valid,
   output logic [IW-1:0] st_req_idx,
   output logic          free_valid,
   output logic [IW-1:0] free_idx
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      MISS_WAIT = 2'd2
   } state_t;

   localparam logic [IW:0] FULL_CNT = (IW+1)'(N);
   localparam logic [IW:0] ONE_CNT  = (IW+1)'(1);

   state_t        state;
   logic [IW-1:0] head;
   logic [IW-1:0] tail;
   logic [IW-1:0] cptr;
   logic [IW:0]   count;   // allocated entries, 0..N
   logic [IW:0]   ccnt;    // committed-but-not-drained entries, always <= count

   logic          do_alloc;
   logic          do_retire;
   logic          do_free;
   logic [IW-1:0] cptr_nxt;
   logic [IW:0]   ccnt_nxt;

   // Full/empty come from the count so head==tail is never ambiguous.
   assign sq_full      = (count == FULL_CNT);
   assign sq_empty     = (count == '0);
   assign head_idx     = head;
   assign tail_idx     = tail;
   assign alloc_idx    = tail;
   assign st_req_valid = (state == REQ);
   assign st_req_idx   = head;

   // Full is judged on registered state, so a free in the same cycle cannot make room.
   assign do_alloc  = alloc_en & ~sq_full & ~squash;
   assign do_retire = retire_en & (ccnt < count);
   assign do_free   = (state == REQ) & st_req_ready & st_hit;

   assign cptr_nxt = cptr + IW'(do_retire);
   assign ccnt_nxt = ccnt + (IW+1)'(do_retire) - (IW+1)'(do_free);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         head       <= '0;
         tail       <= '0;
         cptr       <= '0;
         count      <= '0;
         ccnt       <= '0;
         free_valid <= 1'b0;
         free_idx   <= '0;
      end else begin
         head <= head + IW'(do_free);
         cptr <= cptr_nxt;
         ccnt <= ccnt_nxt;

         // Squash rewinds tail to the post-retire commit pointer; everything
         // committed (including a store in flight) stays queued.
         if (squash) begin
            tail  <= cptr_nxt;
            count <= ccnt_nxt;
         end else begin
            tail  <= tail + IW'(do_alloc);
            count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_free);
         end

         free_valid <= do_free;
         if (do_free) begin
            free_idx <= head;
         end

         unique case (state)
            IDLE: begin
               if ((ccnt != '0) && !drain_hold) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (st_req_ready) begin
                  if (st_hit) begin
                     // Stay in REQ when another committed store remains, giving
                     // one store per cycle back-to-back.
                     if ((ccnt > ONE_CNT) && !drain_hold) begin
                        state <= REQ;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     state <= MISS_WAIT;
                  end
               end
            end
            MISS_WAIT: begin
               // Head is untouched while waiting, so the same entry is reissued.
               if (refill_done) begin
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sq_commit_scheduler.sv
module tb_sq_commit_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic       alloc_en;
   logic       retire_en;
   logic       squash;
   logic       drain_hold;
   logic       st_req_ready;
   logic       st_hit;
   logic       refill_done;
   logic [2:0] alloc_idx;
   logic       sq_full;
   logic       sq_empty;
   logic [2:0] head_idx;
   logic [2:0] tail_idx;
   logic       st_req_valid;
   logic [2:0] st_req_idx;
   logic       free_valid;
   logic [2:0] free_idx;

   int vectors = 0;
   int misses  = 0;

   // Scoreboard: indices expected to be freed, in order, pushed at each accepted retire.
   logic [2:0] sb[$];

   sq_commit_scheduler dut (
      .clock        (clock),
      .reset        (reset),
      .alloc_en     (alloc_en),
      .retire_en    (retire_en),
      .squash       (squash),
      .drain_hold   (drain_hold),
      .st_req_ready (st_req_ready),
      .st_hit       (st_hit),
      .refill_done  (refill_done),
      .alloc_idx    (alloc_idx),
      .sq_full      (sq_full),
      .sq_empty     (sq_empty),
      .head_idx     (head_idx),
      .tail_idx     (tail_idx),
      .st_req_valid (st_req_valid),
      .st_req_idx   (st_req_idx),
      .free_valid   (free_valid),
      .free_idx     (free_idx)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         misses++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Every free pulse must match the oldest outstanding committed index.
   always @(negedge clock) begin
      if (reset && free_valid) begin
         if (sb.size() == 0) begin
            chk("free_spurious", 32'(free_valid), 32'd0);
         end else begin
            chk("free_idx", 32'(free_idx), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset        = 1'b0;
      alloc_en     = 1'b0;
      retire_en    = 1'b0;
      squash       = 1'b0;
      drain_hold   = 1'b0;
      st_req_ready = 1'b0;
      st_hit       = 1'b0;
      refill_done  = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_empty", 32'(sq_empty), 32'd1);
      chk("rst_full", 32'(sq_full), 32'd0);
      chk("rst_head", 32'(head_idx), 32'd0);
      chk("rst_tail", 32'(tail_idx), 32'd0);
      chk("rst_req_valid", 32'(st_req_valid), 32'd0);
      chk("rst_free_valid", 32'(free_valid), 32'd0);
      reset = 1'b1;
      tick();

      // 1: three allocs, three back-to-back retires, drain on hits
      for (int i = 0; i < 3; i++) begin
         alloc_en = 1'b1;
         chk("t1_alloc_idx", 32'(alloc_idx), 32'(i));
         tick();
      end
      alloc_en     = 1'b0;
      st_req_ready = 1'b1;
      st_hit       = 1'b1;
      retire_en    = 1'b1;
      sb.push_back(3'd0);
      tick();
      chk("t1_valid_idle", 32'(st_req_valid), 32'd0);
      sb.push_back(3'd1);
      tick();
      chk("t1_valid_req", 32'(st_req_valid), 32'd1);
      chk("t1_req_idx", 32'(st_req_idx), 32'd0);
      sb.push_back(3'd2);
      tick();
      retire_en = 1'b0;
      chk("t1_req_idx_next", 32'(st_req_idx), 32'd1);
      repeat (3) tick();
      chk("t1_empty", 32'(sq_empty), 32'd1);
      chk("t1_valid_end", 32'(st_req_valid), 32'd0);
      chk("t1_head", 32'(head_idx), 32'd3);
      chk("t1_sb_drained", 32'(sb.size()), 32'd0);
      st_req_ready = 1'b0;
      st_hit       = 1'b0;

      // 2: fill to N, dropped 9th alloc, one drain frees room at idx 0
      do_reset();
      for (int i = 0; i < 8; i++) begin
         alloc_en = 1'b1;
         chk("t2_alloc_idx", 32'(alloc_idx), 32'(i));
         tick();
      end
      chk("t2_full", 32'(sq_full), 32'd1);
      chk("t2_tail", 32'(tail_idx), 32'd0);
      tick();
      alloc_en = 1'b0;
      chk("t2_full_drop", 32'(sq_full), 32'd1);
      chk("t2_tail_drop", 32'(tail_idx), 32'd0);
      chk("t2_not_empty", 32'(sq_empty), 32'd0);
      retire_en = 1'b1;
      sb.push_back(3'd0);
      tick();
      retire_en    = 1'b0;
      st_req_ready = 1'b1;
      st_hit       = 1'b1;
      tick();
      chk("t2_req_valid", 32'(st_req_valid), 32'd1);
      chk("t2_req_idx", 32'(st_req_idx), 32'd0);
      tick();
      st_req_ready = 1'b0;
      st_hit       = 1'b0;
      chk("t2_not_full", 32'(sq_full), 32'd0);
      chk("t2_head", 32'(head_idx), 32'd1);
      alloc_en = 1'b1;
      chk("t2_realloc_idx", 32'(alloc_idx), 32'd0);
      tick();
      alloc_en = 1'b0;
      chk("t2_tail_after", 32'(tail_idx), 32'd1);
      chk("t2_full_again", 32'(sq_full), 32'd1);

      // 3: squash keeps the two committed entries only
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc_en = 1'b1;
         tick();
      end
      alloc_en  = 1'b0;
      retire_en = 1'b1;
      sb.push_back(3'd0);
      tick();
      sb.push_back(3'd1);
      tick();
      retire_en = 1'b0;
      chk("t3_req_valid", 32'(st_req_valid), 32'd1);
      chk("t3_req_idx", 32'(st_req_idx), 32'd0);
      squash   = 1'b1;
      alloc_en = 1'b1;
      tick();
      squash   = 1'b0;
      alloc_en = 1'b0;
      chk("t3_tail", 32'(tail_idx), 32'd2);
      retire_en = 1'b1;
      tick();
      retire_en = 1'b0;
      chk("t3_req_idx_held", 32'(st_req_idx), 32'd0);
      st_req_ready = 1'b1;
      st_hit       = 1'b1;
      repeat (4) tick();
      chk("t3_empty", 32'(sq_empty), 32'd1);
      chk("t3_head", 32'(head_idx), 32'd2);
      chk("t3_tail_end", 32'(tail_idx), 32'd2);
      chk("t3_valid_end", 32'(st_req_valid), 32'd0);

      // 4: miss on idx 5, reissue after refill
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc_en = 1'b1;
         tick();
      end
      alloc_en  = 1'b0;
      retire_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(3'(i));
         tick();
      end
      retire_en = 1'b0;
      repeat (6) tick();
      chk("t4_pre_empty", 32'(sq_empty), 32'd1);
      chk("t4_pre_head", 32'(head_idx), 32'd5);
      alloc_en = 1'b1;
      tick();
      alloc_en  = 1'b0;
      st_hit    = 1'b0;
      retire_en = 1'b1;
      sb.push_back(3'd5);
      tick();
      retire_en = 1'b0;
      tick();
      chk("t4_req_valid", 32'(st_req_valid), 32'd1);
      chk("t4_req_idx", 32'(st_req_idx), 32'd5);
      tick();
      chk("t4_miss_valid", 32'(st_req_valid), 32'd0);
      chk("t4_miss_head", 32'(head_idx), 32'd5);
      st_hit = 1'b1;
      repeat (3) tick();
      chk("t4_wait_valid", 32'(st_req_valid), 32'd0);
      refill_done = 1'b1;
      tick();
      refill_done = 1'b0;
      chk("t4_reissue_valid", 32'(st_req_valid), 32'd1);
      chk("t4_reissue_idx", 32'(st_req_idx), 32'd5);
      tick();
      chk("t4_head_after", 32'(head_idx), 32'd6);
      chk("t4_valid_after", 32'(st_req_valid), 32'd0);
      st_req_ready = 1'b0;
      st_hit       = 1'b0;
      tick();

      // 5: drain 6,7,0 back-to-back while allocating each cycle
      for (int i = 0; i < 3; i++) begin
         alloc_en = 1'b1;
         tick();
      end
      alloc_en  = 1'b0;
      retire_en = 1'b1;
      sb.push_back(3'd6);
      tick();
      sb.push_back(3'd7);
      tick();
      sb.push_back(3'd0);
      tick();
      retire_en    = 1'b0;
      st_req_ready = 1'b1;
      st_hit       = 1'b1;
      alloc_en     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_head", 32'(head_idx), 32'((7 + k) % 8));
         chk("t5_tail", 32'(tail_idx), 32'(2 + k));
         chk("t5_occupancy", 32'(3'(tail_idx - head_idx)), 32'd3);
         chk("t5_not_full", 32'(sq_full), 32'd0);
      end
      alloc_en     = 1'b0;
      st_req_ready = 1'b0;
      st_hit       = 1'b0;
      tick();

      // 6: asynchronous reset while a request waits for ready
      retire_en = 1'b1;
      tick();
      retire_en = 1'b0;
      tick();
      chk("t6_req_valid", 32'(st_req_valid), 32'd1);
      chk("t6_req_idx", 32'(st_req_idx), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_valid_drop", 32'(st_req_valid), 32'd0);
      chk("t6_head", 32'(head_idx), 32'd0);
      chk("t6_tail", 32'(tail_idx), 32'd0);
      chk("t6_empty", 32'(sq_empty), 32'd1);
      chk("t6_full", 32'(sq_full), 32'd0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t6_no_free", 32'(free_valid), 32'd0);
      chk("t6_still_idle", 32'(st_req_valid), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
